// File: rtl/riscv_host_pkg.sv
// Shared types for the RV32I host controller: core status, run result, FSM states, log entry.
package riscv_host_pkg;

    typedef enum logic [1:0] {
        CS_IDLE = 2'b00,
        CS_RUN  = 2'b01,
        CS_HALT = 2'b10,
        CS_EXC  = 2'b11
    } core_status_e;

    typedef enum logic [1:0] {
        RES_OK      = 2'd0,
        RES_EXC     = 2'd1,
        RES_TIMEOUT = 2'd2,
        RES_NOSTART = 2'd3
    } run_result_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_RUN,
        S_RUN,
        S_DONE
    } host_state_e;

    localparam int LOG_PC_W  = 32;
    localparam int LOG_EXC_W = 4;

    typedef struct packed {
        logic [LOG_EXC_W-1:0] exc;
        logic [LOG_PC_W-1:0]  pc;
    } log_entry_t;

endpackage

// File: rtl/riscv_host_log_fifo.sv
// Exception log: first-word-fall-through FIFO with sticky overflow flag.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: push when full without a same-cycle pop is dropped and sets overflow.
module riscv_host_log_fifo #(
    parameter int DW    = 36,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_dat,
    input  logic          pop,
    input  logic          clr_ovf,
    output logic          out_vld,
    output logic [DW-1:0] out_dat,
    output logic          overflow
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          empty;
    logic          full;
    logic          do_pop;
    logic          do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still take the push.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
            if (clr_ovf) begin
                overflow <= 1'b0;
            end else if (push && !do_push) begin
                overflow <= 1'b1;
            end
        end
    end

    assign out_vld = !empty;
    assign out_dat = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/riscv_host_ctrl.sv
// Host controller for the RV32I core: launches runs, monitors status, logs exceptions. Optional watchdog: RV_HOST_TIMEOUT_EN.
// Latency: start_pulse one cycle after command accept; run_done one cycle after terminating status.
// Backpressure: cmd_ready only in IDLE; exception log drops new events when full (sticky log_overflow).
module riscv_host_ctrl
    import riscv_host_pkg::*;
#(
    parameter int PC_W           = 32,
    parameter int EXC_W          = 4,
    parameter int LOG_DEPTH      = 4,
    parameter int CNT_W          = 32,
    parameter int START_WAIT     = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [PC_W-1:0]  cmd_pc,
    input  logic [EXC_W-1:0] cmd_cfg,
    output logic             start_pulse,
    output logic [PC_W-1:0]  start_pc,
    output logic [EXC_W-1:0] core_configuration,
    input  logic [1:0]       core_status,
    input  logic [EXC_W-1:0] core_exceptions,
    input  logic [PC_W-1:0]  core_exceptions_pc,
    output logic             run_done,
    output logic [1:0]       run_result,
    output logic [CNT_W-1:0] run_cycles,
    output logic             log_valid,
    input  logic             log_ready,
    output logic [EXC_W-1:0] log_exc,
    output logic [PC_W-1:0]  log_pc,
    output logic             log_overflow
);
    localparam int WW = $clog2(START_WAIT + 1);
    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    host_state_e      state, state_nxt;
    run_result_e      done_res;
    logic             go_done;
    logic             accept;
    logic             timeout_hit;
    logic [WW-1:0]    wait_cnt;
    logic [EXC_W-1:0] prev_exc;
    logic [PC_W-1:0]  prev_pc;
    logic             cap_en;
    logic             exc_event;

`ifdef RV_HOST_TIMEOUT_EN
    assign timeout_hit = (run_cycles == TO_LIMIT);
`else
    assign timeout_hit = (run_cycles == TO_LIMIT) & 1'b0;
`endif

    assign accept      = cmd_valid && cmd_ready;
    assign cmd_ready   = (state == S_IDLE);
    assign start_pulse = (state == S_LAUNCH);
    assign run_done    = (state == S_DONE);

    always_comb begin
        state_nxt = state;
        done_res  = RES_OK;
        go_done   = 1'b0;
        case (state)
            S_IDLE:   if (cmd_valid) state_nxt = S_LAUNCH;
            S_LAUNCH: state_nxt = S_WAIT_RUN;
            S_WAIT_RUN: begin
                case (core_status_e'(core_status))
                    CS_RUN:  state_nxt = S_RUN;
                    CS_HALT: begin go_done = 1'b1; done_res = RES_OK; end
                    CS_EXC:  begin go_done = 1'b1; done_res = RES_EXC; end
                    default: if (wait_cnt == WW'(START_WAIT - 1)) begin
                        go_done  = 1'b1;
                        done_res = RES_NOSTART;
                    end
                endcase
            end
            S_RUN: begin
                case (core_status_e'(core_status))
                    CS_RUN:  if (timeout_hit) begin go_done = 1'b1; done_res = RES_TIMEOUT; end
                    CS_EXC:  begin go_done = 1'b1; done_res = RES_EXC; end
                    default: begin go_done = 1'b1; done_res = RES_OK; end
                endcase
            end
            default:  state_nxt = S_IDLE;
        endcase
        if (go_done) begin
            state_nxt = S_DONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= S_IDLE;
            start_pc           <= '0;
            core_configuration <= '0;
            run_cycles         <= '0;
            run_result         <= '0;
            wait_cnt           <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                start_pc           <= cmd_pc;
                core_configuration <= cmd_cfg;
                run_cycles         <= '0;
                run_result         <= '0;
            end
            if (state == S_LAUNCH) begin
                start_pc           <= '0;
                core_configuration <= '0;
            end
            wait_cnt <= (state == S_WAIT_RUN) ? wait_cnt + WW'(1) : '0;
            // Only cycles where the core reports RUN are counted; the terminating cycle is not.
            if (state == S_RUN && core_status == CS_RUN && run_cycles != '1) begin
                run_cycles <= run_cycles + CNT_W'(1);
            end
            if (go_done) begin
                run_result <= done_res;
            end
        end
    end

    assign cap_en    = (state == S_WAIT_RUN) || (state == S_RUN) || (state == S_DONE);
    assign exc_event = cap_en && (core_exceptions != '0) &&
                       ({core_exceptions, core_exceptions_pc} != {prev_exc, prev_pc});

    // Previous sample is zeroed outside capture so the first event of a run always logs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_exc <= '0;
            prev_pc  <= '0;
        end else if (cap_en) begin
            prev_exc <= core_exceptions;
            prev_pc  <= core_exceptions_pc;
        end else begin
            prev_exc <= '0;
            prev_pc  <= '0;
        end
    end

    riscv_host_log_fifo #(
        .DW    (EXC_W + PC_W),
        .DEPTH (LOG_DEPTH)
    ) u_log_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (exc_event),
        .push_dat ({core_exceptions, core_exceptions_pc}),
        .pop      (log_ready),
        .clr_ovf  (accept),
        .out_vld  (log_valid),
        .out_dat  ({log_exc, log_pc}),
        .overflow (log_overflow)
    );

endmodule

// File: tb/tb_riscv_host_ctrl.sv
// Directed bench for riscv_host_ctrl: launch, halt, exception log, overflow, no-start, watchdog, reset.
module tb_riscv_host_ctrl;
    import riscv_host_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_pc = '0;
    logic [3:0]  cmd_cfg = '0;
    logic        start_pulse;
    logic [31:0] start_pc;
    logic [3:0]  core_configuration;
    logic [1:0]  core_status = CS_IDLE;
    logic [3:0]  core_exceptions = '0;
    logic [31:0] core_exceptions_pc = '0;
    logic        run_done;
    logic [1:0]  run_result;
    logic [31:0] run_cycles;
    logic        log_valid;
    logic        log_ready = 1'b0;
    logic [3:0]  log_exc;
    logic [31:0] log_pc;
    logic        log_overflow;

    int n_cmp = 0;
    int n_err = 0;

    riscv_host_ctrl #(
        .PC_W(32), .EXC_W(4), .LOG_DEPTH(4), .CNT_W(32),
        .START_WAIT(4), .TIMEOUT_CYCLES(50)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_pc(cmd_pc), .cmd_cfg(cmd_cfg),
        .start_pulse(start_pulse), .start_pc(start_pc), .core_configuration(core_configuration),
        .core_status(core_status), .core_exceptions(core_exceptions),
        .core_exceptions_pc(core_exceptions_pc),
        .run_done(run_done), .run_result(run_result), .run_cycles(run_cycles),
        .log_valid(log_valid), .log_ready(log_ready), .log_exc(log_exc), .log_pc(log_pc),
        .log_overflow(log_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic launch(input logic [31:0] pc, input logic [3:0] cfg, input bit go_run);
        @(negedge clk);
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_pc    = pc;
        cmd_cfg   = cfg;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("start_pulse_hi", start_pulse, 1);
        chk("start_pc", start_pc, pc);
        chk("core_cfg", core_configuration, cfg);
        chk("cmd_ready_busy", cmd_ready, 0);
        chk("ovf_cleared", log_overflow, 0);
        if (go_run) core_status = CS_RUN;
        @(negedge clk);
        chk("start_pulse_lo", start_pulse, 0);
        chk("start_pc_zero", start_pc, 0);
        chk("core_cfg_zero", core_configuration, 0);
        if (go_run) @(negedge clk);
    endtask

    task automatic wait_done(input int maxc);
        bit seen = 1'b0;
        for (int k = 0; k < maxc; k++) begin
            @(negedge clk);
            if (run_done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen", seen, 1);
    endtask

    task automatic pop_chk(input log_entry_t e);
        chk("log_valid", log_valid, 1);
        chk("log_exc", log_exc, e.exc);
        chk("log_pc", log_pc, e.pc);
        log_ready = 1'b1;
        @(negedge clk);
        log_ready = 1'b0;
    endtask

    task automatic scenario_halt();
        launch(32'h3, 4'h1, 1'b1);
        repeat (20) @(negedge clk);
        core_status = CS_HALT;
        @(negedge clk);
        chk("halt_done", run_done, 1);
        chk("halt_result", run_result, RES_OK);
        chk("halt_cycles", run_cycles, 20);
        core_status = CS_IDLE;
        @(negedge clk);
        chk("done_one_cycle", run_done, 0);
        chk("cycles_held", run_cycles, 20);
        chk("halt_no_log", log_valid, 0);
    endtask

    initial begin
        bit seen;
        #12;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_start_pulse", start_pulse, 0);
        chk("rst_run_done", run_done, 0);
        chk("rst_run_cycles", run_cycles, 0);
        chk("rst_log_valid", log_valid, 0);
        chk("rst_log_ovf", log_overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: normal halt after 20 RUN cycles
        scenario_halt();

        // 2: repeated sample logs once, new vector logs again, EXC terminates
        launch(32'h80, 4'hF, 1'b1);
        core_exceptions = 4'h2; core_exceptions_pc = 32'h34;
        repeat (3) @(negedge clk);
        core_exceptions = 4'h1; core_exceptions_pc = 32'h40;
        @(negedge clk);
        core_exceptions = '0; core_exceptions_pc = '0;
        core_status = CS_EXC;
        @(negedge clk);
        chk("exc_done", run_done, 1);
        chk("exc_result", run_result, RES_EXC);
        core_status = CS_IDLE;
        pop_chk('{exc: 4'h2, pc: 32'h34});
        pop_chk('{exc: 4'h1, pc: 32'h40});
        chk("exc_log_empty", log_valid, 0);

        // 3a: six events into a four-deep log, first four kept
        launch(32'h100, 4'h0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            core_exceptions = 4'(i + 1); core_exceptions_pc = 32'h100 + 32'(4 * i);
            @(negedge clk);
        end
        core_exceptions = '0; core_exceptions_pc = '0;
        core_status = CS_HALT;
        @(negedge clk);
        chk("ovf_done", run_done, 1);
        chk("ovf_set", log_overflow, 1);
        core_status = CS_IDLE;
        for (int i = 0; i < 4; i++) pop_chk('{exc: 4'(i + 1), pc: 32'h100 + 32'(4 * i)});
        chk("ovf_log_empty", log_valid, 0);
        chk("ovf_sticky", log_overflow, 1);

        // 3b: push and pop together while full drops nothing
        launch(32'h200, 4'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            core_exceptions = 4'(i + 1); core_exceptions_pc = 32'h200 + 32'(4 * i);
            @(negedge clk);
        end
        core_exceptions = 4'h5; core_exceptions_pc = 32'h210;
        log_ready = 1'b1;
        @(negedge clk);
        log_ready = 1'b0;
        core_exceptions = '0; core_exceptions_pc = '0;
        core_status = CS_HALT;
        @(negedge clk);
        chk("pp_done", run_done, 1);
        chk("pp_no_ovf", log_overflow, 0);
        core_status = CS_IDLE;
        for (int i = 1; i < 5; i++) pop_chk('{exc: 4'(i + 1), pc: 32'h200 + 32'(4 * i)});
        chk("pp_log_empty", log_valid, 0);

        // 4: core never leaves IDLE
        launch(32'h10, 4'h0, 1'b0);
        repeat (3) @(negedge clk);
        chk("nostart_early", run_done, 0);
        @(negedge clk);
        chk("nostart_done", run_done, 1);
        chk("nostart_result", run_result, RES_NOSTART);
        chk("nostart_cycles", run_cycles, 0);

        // 5: status stuck in RUN
        launch(32'h20, 4'h0, 1'b1);
`ifdef RV_HOST_TIMEOUT_EN
        wait_done(100);
        chk("wd_result", run_result, RES_TIMEOUT);
        chk("wd_cycles", run_cycles, 50);
        core_status = CS_IDLE;
`else
        seen = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (run_done) seen = 1'b1;
        end
        chk("no_watchdog", seen, 0);
        chk("nowd_cycles", run_cycles, 200);
        core_status = CS_HALT;
        wait_done(4);
        chk("nowd_result", run_result, RES_OK);
        core_status = CS_IDLE;
`endif
        @(negedge clk);

        // 6: asynchronous reset mid-run, then a fresh run
        launch(32'h44, 4'h2, 1'b1);
        core_exceptions = 4'h8; core_exceptions_pc = 32'h500;
        repeat (5) @(negedge clk);
        core_exceptions = '0; core_exceptions_pc = '0;
        chk("pre_rst_log", log_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cmd_ready", cmd_ready, 1);
        chk("arst_run_done", run_done, 0);
        chk("arst_run_cycles", run_cycles, 0);
        chk("arst_log_valid", log_valid, 0);
        chk("arst_log_pc", log_pc, 0);
        chk("arst_start_pc", start_pc, 0);
        core_status = CS_IDLE;
        @(negedge clk);
        rst_n = 1'b1;
        scenario_halt();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
